// File: rtl/regfile_wr_demux.sv
// regfile_wr_demux: register bank for the single-cycle datapath.
//   One write port demultiplexes wdata into register waddr (x0 hardwired to 0).
//   Two combinational read ports feed the ALU operand muxes.
//   wr_count is a saturating count of effective writes (we=1, waddr!=0).
// Build option: define REGFILE_BYPASS_EN for write-first forwarding on both
//   read ports; without it a same-cycle read returns the old register value.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   we, waddr, wdata   write port
//   raddr0, rdata0     read port 0 (combinational)
//   raddr1, rdata1     read port 1 (combinational)
//   wr_count           saturating effective-write count (registered)
module regfile_wr_demux #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NREG  = 32,
   parameter int unsigned AW    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr0,
   input  logic [AW-1:0]    raddr1,
   output logic [WIDTH-1:0] rdata0,
   output logic [WIDTH-1:0] rdata1,
   output logic [7:0]       wr_count
);

   localparam int unsigned CW      = 8;
   localparam logic [CW-1:0] CNT_MAX = CW'(255);

   logic [WIDTH-1:0] regs [NREG];
   logic             wr_eff_c;

   // Writes to x0 are discarded and do not count.
   assign wr_eff_c = we && (waddr != '0);

   // Write demux: only register waddr loads; reset clears the whole bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_eff_c) begin
         regs[waddr] <= wdata;
      end
   end

   // Saturating effective-write counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_count <= '0;
      end else if (wr_eff_c && (wr_count != CNT_MAX)) begin
         wr_count <= wr_count + CW'(1);
      end
   end

   // Read port 0; x0 forced to zero independently of the stored entry.
   always_comb begin
      rdata0 = '0;
      if (raddr0 != '0) begin
         rdata0 = regs[raddr0];
`ifdef REGFILE_BYPASS_EN
         if (wr_eff_c && (raddr0 == waddr)) begin
            rdata0 = wdata;
         end
`endif
      end
   end

   // Read port 1; same structure as port 0.
   always_comb begin
      rdata1 = '0;
      if (raddr1 != '0) begin
         rdata1 = regs[raddr1];
`ifdef REGFILE_BYPASS_EN
         if (wr_eff_c && (raddr1 == waddr)) begin
            rdata1 = wdata;
         end
`endif
      end
   end

endmodule

// File: tb/tb_regfile_wr_demux.sv
// tb_regfile_wr_demux: scoreboard bench for regfile_wr_demux.
//   Expected values are queued when stimulus is driven and popped when the
//   corresponding DUT output is sampled (1-2 time units after a rising edge).
module tb_regfile_wr_demux;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr0;
   logic [4:0]  raddr1;
   logic [31:0] rdata0;
   logic [31:0] rdata1;
   logic [7:0]  wr_count;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];
   logic [31:0] exp;
   int          model_count = 0;

   regfile_wr_demux #(.WIDTH(32), .NREG(32), .AW(5)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .raddr0   (raddr0),
      .raddr1   (raddr1),
      .rdata0   (rdata0),
      .rdata1   (rdata1),
      .wr_count (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus helper: one write cycle, returns 1 time unit after the edge.
   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1; waddr = a; wdata = d;
      @(posedge clk); #1;
      we = 1'b0;
      if (a != 5'd0) model_count = (model_count < 255) ? model_count + 1 : 255;
   endtask

   task automatic test_reset();
      do_write(5'd2, 32'hCAFE_F00D);
      raddr0 = 5'd2;
      exp_q.push_back(32'hCAFE_F00D);
      #1; exp = exp_q.pop_front(); checks++;
      if (rdata0 !== exp) begin
         errors++; $display("FAIL pre_reset_write got %h want %h", rdata0, exp);
      end
      // Assert reset mid-cycle: outputs must clear without a clock edge.
      rst_n = 1'b0; model_count = 0;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1; exp = exp_q.pop_front(); checks++;
      if (rdata0 !== exp) begin
         errors++; $display("FAIL async_reset_rdata got %h want %h", rdata0, exp);
      end
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, wr_count} !== exp) begin
         errors++; $display("FAIL async_reset_count got %0d want %0d", wr_count, exp);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         raddr0 = 5'(i);
         exp_q.push_back(32'h0);
         #1; exp = exp_q.pop_front(); checks++;
         if (rdata0 !== exp) begin
            errors++; $display("FAIL reset_sweep addr %0d got %h want %h", i, rdata0, exp);
         end
      end
      exp_q.push_back(32'(model_count));
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, wr_count} !== exp) begin
         errors++; $display("FAIL reset_count got %0d want %0d", wr_count, exp);
      end
   endtask

   task automatic test_demux();
      do_write(5'd5, 32'hAAAA_AAAA);
      do_write(5'd6, 32'h5555_5555);
      raddr0 = 5'd5; raddr1 = 5'd6;
      exp_q.push_back(32'hAAAA_AAAA); exp_q.push_back(32'h5555_5555);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (rdata0 !== exp) begin
         errors++; $display("FAIL demux_r5 got %h want %h", rdata0, exp);
      end
      exp = exp_q.pop_front(); checks++;
      if (rdata1 !== exp) begin
         errors++; $display("FAIL demux_r6 got %h want %h", rdata1, exp);
      end
      raddr0 = 5'd4; raddr1 = 5'd7;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'd2);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (rdata0 !== exp) begin
         errors++; $display("FAIL demux_r4 got %h want %h", rdata0, exp);
      end
      exp = exp_q.pop_front(); checks++;
      if (rdata1 !== exp) begin
         errors++; $display("FAIL demux_r7 got %h want %h", rdata1, exp);
      end
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, wr_count} !== exp) begin
         errors++; $display("FAIL demux_count got %0d want %0d", wr_count, exp);
      end
   endtask

   task automatic test_x0_and_we();
      raddr0 = 5'd0;
      do_write(5'd0, 32'h1234_5678);
      exp_q.push_back(32'h0); exp_q.push_back(32'd2);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (rdata0 !== exp) begin
         errors++; $display("FAIL x0_read got %h want %h", rdata0, exp);
      end
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, wr_count} !== exp) begin
         errors++; $display("FAIL x0_count got %0d want %0d", wr_count, exp);
      end
      // we=0: nothing changes.
      we = 1'b0; waddr = 5'd9; wdata = 32'h8765_4321; raddr1 = 5'd9;
      @(posedge clk); #1;
      exp_q.push_back(32'h0); exp_q.push_back(32'd2);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (rdata1 !== exp) begin
         errors++; $display("FAIL we0_r9 got %h want %h", rdata1, exp);
      end
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, wr_count} !== exp) begin
         errors++; $display("FAIL we0_count got %0d want %0d", wr_count, exp);
      end
   endtask

   task automatic test_same_cycle();
      do_write(5'd10, 32'h1111_1111);
      raddr0 = 5'd10; raddr1 = 5'd10;
      we = 1'b1; waddr = 5'd10; wdata = 32'h8765_4321;
`ifdef REGFILE_BYPASS_EN
      exp_q.push_back(32'h8765_4321); exp_q.push_back(32'h8765_4321);
`else
      exp_q.push_back(32'h1111_1111); exp_q.push_back(32'h1111_1111);
`endif
      #1;
      exp = exp_q.pop_front(); checks++;
      if (rdata0 !== exp) begin
         errors++; $display("FAIL same_cycle_p0 got %h want %h", rdata0, exp);
      end
      exp = exp_q.pop_front(); checks++;
      if (rdata1 !== exp) begin
         errors++; $display("FAIL same_cycle_p1 got %h want %h", rdata1, exp);
      end
      @(posedge clk); #1; we = 1'b0;
      model_count = model_count + 1;
      exp_q.push_back(32'h8765_4321); exp_q.push_back(32'h8765_4321);
      exp_q.push_back(32'(model_count));
      #1;
      exp = exp_q.pop_front(); checks++;
      if (rdata0 !== exp) begin
         errors++; $display("FAIL next_cycle_p0 got %h want %h", rdata0, exp);
      end
      exp = exp_q.pop_front(); checks++;
      if (rdata1 !== exp) begin
         errors++; $display("FAIL next_cycle_p1 got %h want %h", rdata1, exp);
      end
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, wr_count} !== exp) begin
         errors++; $display("FAIL same_cycle_count got %0d want %0d", wr_count, exp);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) begin
         do_write(5'd1, 32'(i));
         if (model_count == 255 && i < 300 - 1 && wr_count == 8'd255) begin
            // fall through; final values checked below
         end
      end
      raddr0 = 5'd1;
      exp_q.push_back(32'd299); exp_q.push_back(32'(model_count));
      #1;
      exp = exp_q.pop_front(); checks++;
      if (rdata0 !== exp) begin
         errors++; $display("FAIL sat_r1 got %h want %h", rdata0, exp);
      end
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, wr_count} !== exp) begin
         errors++; $display("FAIL sat_count got %0d want %0d", wr_count, exp);
      end
   endtask

   task automatic test_mid_reset();
      we = 1'b1; waddr = 5'd3; wdata = 32'hDEAD_BEEF;
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      we = 1'b0; rst_n = 1'b1; model_count = 0;
      raddr0 = 5'd3; raddr1 = 5'd1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'd0);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (rdata0 !== exp) begin
         errors++; $display("FAIL mid_reset_r3 got %h want %h", rdata0, exp);
      end
      exp = exp_q.pop_front(); checks++;
      if (rdata1 !== exp) begin
         errors++; $display("FAIL mid_reset_r1 got %h want %h", rdata1, exp);
      end
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, wr_count} !== exp) begin
         errors++; $display("FAIL mid_reset_count got %0d want %0d", wr_count, exp);
      end
      // Bank resumes normally after reset.
      do_write(5'd31, 32'h0BAD_F00D);
      raddr1 = 5'd31;
      exp_q.push_back(32'h0BAD_F00D); exp_q.push_back(32'(model_count));
      #1;
      exp = exp_q.pop_front(); checks++;
      if (rdata1 !== exp) begin
         errors++; $display("FAIL post_reset_r31 got %h want %h", rdata1, exp);
      end
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, wr_count} !== exp) begin
         errors++; $display("FAIL post_reset_count got %0d want %0d", wr_count, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr0 = '0; raddr1 = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      test_reset();
      test_demux();
      test_x0_and_we();
      test_same_cycle();
      test_saturation();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_wr_demux.md
Name: regfile_wr_demux

Overview:
- Register bank for the single-cycle datapath.
- One write port demultiplexes write data into exactly one of NREG registers, selected by the write address.
- Two combinational read ports select registers back out to the ALU operand path.
- Location: between the write-back select stage and the ALU operand muxes. x0 is hardwired to zero (RISC-V/MIPS convention).

Parameters:
- WIDTH, 32, data width of each register and of every data port.
- NREG, 32, number of registers; power of two, at least 2.
- AW, 5, address width; must equal log2(NREG).

Ports:
- clk  input  1  single clock; all register updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- we  input  1  write enable; sampled on the rising clk edge.
- waddr  input  AW  write destination select (demux select).
- wdata  input  WIDTH  write data routed to register waddr.
- raddr0  input  AW  read port 0 select.
- raddr1  input  AW  read port 1 select.
- rdata0  output  WIDTH  contents of register raddr0.
- rdata1  output  WIDTH  contents of register raddr1.
- wr_count  output  8  saturating count of accepted (effective) writes.

Behaviour:
- Reset:
  - rst_n low forces all registers to 0 and wr_count to 0 immediately, without waiting for clk.
  - rdata0 and rdata1 therefore read 0 while reset is held.
  - rst_n is released synchronously to clk by the system.
- Write demux:
  - On a rising clk edge with we=1 and waddr != 0, register[waddr] <= wdata.
  - All other registers hold their value; exactly one register is updated per cycle.
- x0 rule:
  - A write with waddr=0 is discarded; register 0 always reads 0.
  - wr_count does not increment on a discarded write.
- we=0: no register changes, regardless of waddr and wdata.
- Read ports:
  - Purely combinational; rdataN = register[raddrN] within the same cycle.
  - Zero cycles of latency from an address change.
- Write latency: written data is visible on the read ports from the cycle after the write edge (without the bypass feature).
- Simultaneous write and read of the same address, no bypass: the read returns the old value in that cycle and the new value in the next cycle.
- Both read ports may select the same register; both return the identical value.
- wr_count:
  - Increments by 1 on each effective write (we=1, waddr != 0).
  - Saturates at 255; never wraps.
- Reset mid-operation: an asserted rst_n overrides any write in the same cycle; that write is lost.
- Address range: waddr, raddr0 and raddr1 are always in range because NREG = 2^AW; no out-of-range handling is needed.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-first forwarding on both read ports.
  - If we=1, waddr != 0 and raddrN == waddr, then rdataN = wdata combinationally in the same cycle.
  - raddrN=0 still returns 0.
- Not defined: read-old-value behaviour as specified in Behaviour; no forwarding logic is synthesised.

Test Plan:
- Reset values: rst_n=0 asynchronously mid-cycle, then release; sweep raddr0 over 0..31 -> rdata0 reads 0 at every address, wr_count=0.
- Demux routing: write 32'hAAAAAAAA to addr 5, then 32'h55555555 to addr 6; read 5 on port 0 and 6 on port 1 -> rdata0=AAAAAAAA, rdata1=55555555; addr 4 and addr 7 read 0; wr_count=2.
- x0 discard and we gating:
  - we=1, waddr=0, wdata=32'h12345678 -> raddr0=0 reads 0, wr_count unchanged.
  - we=0, waddr=9, wdata=32'h87654321 -> register 9 stays 0.
- Same-cycle read/write on addr 10, register 10 initially 32'h11111111, writing 32'h87654321:
  - Without the macro: same cycle reads 11111111; next cycle reads 87654321.
  - With REGFILE_BYPASS_EN: same cycle reads 87654321.
- Saturation and mid-operation reset:
  - 300 writes to addr 1 -> wr_count=255.
  - Pulse rst_n low during a write of 32'hDEADBEEF to addr 3 -> register 3 and wr_count read 0 after release.
